// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } elev_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int floor_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter. The expire output flags the cycle whose clock edge
// completes the count (enabled while the count sits at 1).
module elev_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over counting, and the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire must not depend on load: the controller derives its reload from it.
    assign expire = en && (cnt_q == W'(1));

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller: latches calls into a pending bitmap, keeps
// travelling while calls remain ahead, reverses otherwise. Travel time per
// floor and door dwell are programmable cycle counts.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter  int N_FLOORS     = 8,
    parameter  int FLOOR_CYCLES = 4,
    parameter  int DOOR_CYCLES  = 3,
    localparam int FW           = floor_w(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FW-1:0]       req_floor,
    input  logic                req_valid,
    output logic [FW-1:0]       curr_floor,
    output logic                door_open,
    output logic                moving,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] pending,
    output logic                req_err
);

    localparam int FSPAN = 1 << FW;
    localparam int TMAX  = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
    localparam int TW    = floor_w(TMAX + 1);
    localparam logic [TW-1:0] FLOOR_LOAD = TW'(FLOOR_CYCLES);
    localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_CYCLES);

    elev_state_t         state_q;
    logic [FW-1:0]       curr_q;
    logic                dir_q;
    logic [N_FLOORS-1:0] pend_q;
    logic                door_q;
    logic                mov_q;
    logic                err_q;

    logic [FSPAN-1:0]    valid_map;
    logic                in_range;
    logic                req_accept;
    logic                recall;
    logic [N_FLOORS-1:0] set_mask;
    logic [N_FLOORS-1:0] pend_set;
    logic [N_FLOORS-1:0] above;
    logic [N_FLOORS-1:0] below;
    logic [N_FLOORS-1:0] clr_curr;
    logic [N_FLOORS-1:0] clr_next;
    logic                ahead;
    logic                behind;
    logic [FW-1:0]       next_floor;
    logic                stop_next;
    logic                idle_open;
    logic                idle_go;
    logic                step;
    logic                travel_load;
    logic                travel_en;
    logic                travel_exp;
    logic                door_load;
    logic                door_en;
    logic                door_exp;

    // Call intake, direction masks and timer control derived from registered state.
    always_comb begin
        // Index codes that name a real floor; avoids a constant-range compare.
        for (int i = 0; i < FSPAN; i++) begin
            valid_map[i] = (i < N_FLOORS);
        end
        in_range   = valid_map[req_floor];
        req_accept = req_valid && in_range;
        // A re-call for the floor whose door is open only extends the dwell.
        recall     = req_accept && (state_q == DOOR_OPEN) && (req_floor == curr_q);

        next_floor = dir_q ? (curr_q + 1'b1) : (curr_q - 1'b1);

        for (int i = 0; i < N_FLOORS; i++) begin
            set_mask[i] = req_accept && !recall && (req_floor == FW'(i));
            above[i]    = (i > int'(curr_q));
            below[i]    = (i < int'(curr_q));
            clr_curr[i] = (curr_q == FW'(i));
            clr_next[i] = (next_floor == FW'(i));
        end
        pend_set = pend_q | set_mask;

        // Ahead/behind look only at registered calls.
        ahead  = dir_q ? |(pend_q & above) : |(pend_q & below);
        behind = dir_q ? |(pend_q & below) : |(pend_q & above);

        // Calls landing on the arrival edge still stop the cabin there.
        stop_next = pend_set[next_floor];

        idle_open   = (state_q == IDLE) && pend_q[curr_q];
        idle_go     = (state_q == IDLE) && !pend_q[curr_q] && (ahead || behind);
        step        = (state_q == MOVING) && travel_exp;

        travel_en   = (state_q == MOVING);
        travel_load = idle_go || (step && !stop_next);
        door_en     = (state_q == DOOR_OPEN);
        door_load   = idle_open || (step && stop_next) || recall;
    end

    elev_timer #(.W(TW)) u_travel_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (travel_load),
        .load_val (FLOOR_LOAD),
        .en       (travel_en),
        .expire   (travel_exp)
    );

    elev_timer #(.W(TW)) u_door_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (door_load),
        .load_val (DOOR_LOAD),
        .en       (door_en),
        .expire   (door_exp)
    );

    // Controller FSM with registered outputs; serving a floor clears its call.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            curr_q  <= '0;
            dir_q   <= 1'b1;
            pend_q  <= '0;
            door_q  <= 1'b0;
            mov_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q  <= req_valid && !in_range;
            pend_q <= pend_set;
            case (state_q)
                IDLE: begin
                    if (pend_q[curr_q]) begin
                        state_q <= DOOR_OPEN;
                        door_q  <= 1'b1;
                        pend_q  <= pend_set & ~clr_curr;
                    end else if (ahead) begin
                        state_q <= MOVING;
                        mov_q   <= 1'b1;
                    end else if (behind) begin
                        state_q <= MOVING;
                        mov_q   <= 1'b1;
                        dir_q   <= ~dir_q;
                    end
                end
                MOVING: begin
                    if (travel_exp) begin
                        curr_q <= next_floor;
                        if (stop_next) begin
                            state_q <= DOOR_OPEN;
                            mov_q   <= 1'b0;
                            door_q  <= 1'b1;
                            pend_q  <= pend_set & ~clr_next;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (door_exp && !recall) begin
                        state_q <= IDLE;
                        door_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    door_q  <= 1'b0;
                    mov_q   <= 1'b0;
                end
            endcase
        end
    end

    assign curr_floor = curr_q;
    assign door_open  = door_q;
    assign moving     = mov_q;
    assign dir_up     = dir_q;
    assign pending    = pend_q;
    assign req_err    = err_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: expected floor steps, door openings
// and closings are queued with their clock-edge numbers; a monitor pops and
// compares them as the cabin outputs change.
module tb_elevator_scan_ctrl;

    localparam int EV_STEP  = 0;
    localparam int EV_STOP  = 1;
    localparam int EV_CLOSE = 2;

    typedef struct {
        int kind;
        int floor;
        int dir;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_floor = 3'd0;
    logic       req_valid = 1'b0;
    logic [2:0] curr_floor;
    logic       door_open;
    logic       moving;
    logic       dir_up;
    logic [7:0] pending;
    logic       req_err;

    logic [2:0] r6_floor = 3'd0;
    logic       r6_valid = 1'b0;
    logic [2:0] c6_floor;
    logic       d6_open;
    logic       m6;
    logic       u6;
    logic [5:0] p6;
    logic       e6;

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    logic [2:0] prev_floor;
    logic       prev_door;

    elevator_scan_ctrl #(.N_FLOORS(8), .FLOOR_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .req_floor(req_floor), .req_valid(req_valid),
        .curr_floor(curr_floor), .door_open(door_open), .moving(moving),
        .dir_up(dir_up), .pending(pending), .req_err(req_err)
    );

    elevator_scan_ctrl #(.N_FLOORS(6), .FLOOR_CYCLES(4), .DOOR_CYCLES(3)) dut6 (
        .clk(clk), .rst(rst), .req_floor(r6_floor), .req_valid(r6_valid),
        .curr_floor(c6_floor), .door_open(d6_open), .moving(m6),
        .dir_up(u6), .pending(p6), .req_err(e6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int fl, input int dir, input int c);
        ev_t e;
        e.kind = kind; e.floor = fl; e.dir = dir; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Steps every 4 cycles from first_step, door opens on the last step, closes at close_cyc.
    task automatic push_trip(input int from, input int to, input int first_step, input int close_cyc);
        int d;
        int n;
        d = (to > from) ? 1 : 0;
        n = (to > from) ? (to - from) : (from - to);
        for (int i = 1; i <= n; i++) begin
            push_ev(EV_STEP, d ? from + i : from - i, d, first_step + 4 * (i - 1));
        end
        push_ev(EV_STOP, to, d, first_step + 4 * (n - 1));
        push_ev(EV_CLOSE, to, -1, close_cyc);
    endtask

    task automatic check_ev(input int kind, input int fl, input int dir);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got kind=%0d floor=%0d at cycle %0d, expected no event", kind, fl, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.floor != fl || e.cyc != cyc || (e.dir >= 0 && e.dir != dir)) begin
                n_bad++;
                $display("FAIL event: got kind=%0d floor=%0d dir=%0d cyc=%0d, expected kind=%0d floor=%0d dir=%0d cyc=%0d",
                         kind, fl, dir, cyc, e.kind, e.floor, e.dir, e.cyc);
            end
        end
    endtask

    // Monitor: every floor change, door rise and door fall is one scoreboard event.
    always @(negedge clk) begin
        if (rst) begin
            prev_floor = curr_floor;
            prev_door  = door_open;
        end else begin
            if (curr_floor !== prev_floor) check_ev(EV_STEP, int'(curr_floor), int'(dir_up));
            if (door_open === 1'b1 && prev_door === 1'b0) check_ev(EV_STOP, int'(curr_floor), int'(dir_up));
            if (door_open === 1'b0 && prev_door === 1'b1) check_ev(EV_CLOSE, int'(curr_floor), int'(dir_up));
            prev_floor = curr_floor;
            prev_door  = door_open;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive a one-cycle call so that it is sampled on clock edge e.
    task automatic call_at(input int f, input int e);
        wait_cyc(e - 1);
        if (cyc != e - 1) begin
            n_bad++;
            $display("FAIL sched: call for edge %0d issued at cycle %0d", e, cyc);
        end
        req_floor = 3'(f);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic call6_at(input int f, input int e);
        wait_cyc(e - 1);
        r6_floor = 3'(f);
        r6_valid = 1'b1;
        @(negedge clk);
        r6_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        wait_cyc(2);
        rst = 1'b0;
        chk("rst_curr", 32'(curr_floor), 0);
        chk("rst_door", 32'(door_open), 0);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_dir", 32'(dir_up), 1);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_err", 32'(req_err), 0);

        // Out-of-range calls on the 6-floor instance.
        call6_at(7, 5);
        chk("err6_pulse", 32'(e6), 1);
        chk("err6_pend", 32'(p6), 0);
        chk("err6_idle", 32'(m6), 0);
        @(negedge clk);
        chk("err6_one_cycle", 32'(e6), 0);
        chk("err6_pend2", 32'(p6), 0);
        call6_at(6, 8);
        chk("err6_eqN", 32'(e6), 1);
        call6_at(5, 10);
        chk("err6_top_ok", 32'(e6), 0);
        chk("err6_top_pend", 32'(p6), 'h20);

        // Single call 0 -> 4.
        push_trip(0, 4, 25, 40);
        call_at(4, 20);
        chk("t2_pending", 32'(pending), 'h10);
        chk("t2_not_moving", 32'(moving), 0);
        @(negedge clk);
        chk("t2_moving", 32'(moving), 1);
        wait_cyc(42);
        chk("t2_pend_clr", 32'(pending), 0);
        chk("t2_idle", 32'(moving), 0);
        chk("t2_floor", 32'(curr_floor), 4);

        // Reset while travelling towards 7.
        push_ev(EV_STEP, 5, 1, 50);
        call_at(7, 45);
        wait_cyc(51);
        chk("t1_mid_moving", 32'(moving), 1);
        chk("t1_mid_pend", 32'(pending), 'h80);
        rst = 1'b1;
        wait_cyc(53);
        rst = 1'b0;
        chk("t1_curr", 32'(curr_floor), 0);
        chk("t1_door", 32'(door_open), 0);
        chk("t1_moving", 32'(moving), 0);
        chk("t1_dir", 32'(dir_up), 1);
        chk("t1_pending", 32'(pending), 0);
        chk("t1_err", 32'(req_err), 0);
        wait_cyc(56);
        chk("t1_stays_idle", 32'(moving), 0);

        // SCAN order 4,5,6 then reverse to 0.
        push_trip(0, 4, 65, 80);
        push_trip(4, 5, 85, 88);
        push_trip(5, 6, 93, 96);
        push_trip(6, 0, 101, 124);
        call_at(4, 60);
        call_at(6, 65);
        call_at(5, 70);
        call_at(0, 75);
        wait_cyc(96);
        chk("t3_dir_before", 32'(dir_up), 1);
        wait_cyc(97);
        chk("t3_dir_after", 32'(dir_up), 0);
        wait_cyc(125);
        chk("t3_pend_clr", 32'(pending), 0);

        // Door re-call at 3, then 1 and 6 queued together: 6 first, then 1.
        push_trip(0, 3, 135, 148);
        push_trip(3, 6, 153, 164);
        push_trip(6, 1, 169, 188);
        call_at(3, 130);
        call_at(3, 145);
        chk("t4_door_held", 32'(door_open), 1);
        chk("t4_pend3_clear", 32'(pending), 0);
        call_at(1, 146);
        call_at(6, 147);
        chk("t6_pend_both", 32'(pending), 'h42);
        chk("t6_door_still", 32'(door_open), 1);
        wait_cyc(165);
        chk("t6_reverse", 32'(dir_up), 0);

        wait_cyc(195);
        chk("events_left", 32'(exp_q.size()), 0);
        chk("end_pending", 32'(pending), 0);
        chk("end_floor", 32'(curr_floor), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
